// File: rtl/mini_cpu_pkg.sv
// rtl/mini_cpu_pkg.sv - shared types and defaults for the memory responder
package mini_cpu_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

  typedef enum logic [1:0] {
    REQ_RD  = 2'd0,
    REQ_WR  = 2'd1,
    REQ_BAD = 2'd2
  } req_t;

  // Read and Write together is an illegal request; it is answered with Err.
  function automatic req_t decode_req(input logic rd, input logic wr);
    if (rd && wr) return REQ_BAD;
    if (wr) return REQ_WR;
    return REQ_RD;
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous word RAM, no reset
module mem_array #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 32,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // One access per enabled cycle: write, or registered read that holds otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory-side responder with programmable wait states
module mem_responder
  import mini_cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int DEPTH       = 512,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] Wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              Ready,
  output logic              Busy,
  output logic              Err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  mem_state_t        state, next_state;
  logic [3:0]        cnt;
  req_t              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_valid;

  req_t              cur_req;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              cur_addr_ok;
  logic              q_addr_ok;
  logic              enter_resp;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] rdata;

  // In IDLE the live inputs feed the access (zero-wait case); afterwards the captured copies do.
  always_comb begin
    cur_req   = req_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_req   = decode_req(Read, Write);
      cur_addr  = Addr;
      cur_wdata = Wdata;
    end
    cur_addr_ok = ({1'b0, cur_addr} < DEPTH_X);
    q_addr_ok   = ({1'b0, addr_q} < DEPTH_X);
  end

  // Next-state, array strobe and output decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (Read || Write) next_state = (WAIT_STATES == 0) ? RESP : WAIT;
      WAIT: if (cnt == 4'd0) next_state = RESP;
      RESP: next_state = HOLD;
      HOLD: if (!Read && !Write) next_state = IDLE;
      default: next_state = IDLE;
    endcase
    enter_resp = (next_state == RESP) && (state != RESP);
    mem_en     = enter_resp && cur_addr_ok && (cur_req != REQ_BAD);
    mem_we     = (cur_req == REQ_WR);
    Ready      = (state == RESP);
    Busy       = (state != IDLE);
    Err        = (state == RESP) && ((req_q == REQ_BAD) || !q_addr_ok);
    Mdatain    = rd_valid ? rdata : '0;
  end

  // State register.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Request capture and wait-state countdown.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      cnt     <= 4'd0;
      req_q   <= REQ_RD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE) begin
      if (Read || Write) begin
        req_q   <= cur_req;
        addr_q  <= Addr;
        wdata_q <= Wdata;
        cnt     <= 4'(WAIT_STATES - 1);
      end
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // The RAM has no reset, so this flag zeroes Mdatain after reset or an out-of-range read.
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      rd_valid <= 1'b0;
    end else if (enter_resp && cur_req == REQ_RD) begin
      rd_valid <= cur_addr_ok;
    end
  end

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem_array (
    .clk   (Clock),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (cur_addr[IDX_W-1:0]),
    .wdata (cur_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

  logic        Clock = 1'b0;
  logic        clear;
  logic [8:0]  Addr;
  logic [31:0] Wdata;
  logic        rd  [3];
  logic        wr  [3];
  logic [31:0] md  [3];
  logic        rdy [3];
  logic        bsy [3];
  logic        er  [3];

  int ws_of    [3] = '{1, 0, 3};
  int depth_of [3] = '{256, 512, 512};

  logic [31:0] mem_m [3][512];
  bit          kn    [3][512];
  logic [31:0] mdm   [3];

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clock = ~Clock;

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_STATES(1)) u_ws1 (
    .Clock(Clock), .clear(clear), .Read(rd[0]), .Write(wr[0]), .Addr(Addr), .Wdata(Wdata),
    .Mdatain(md[0]), .Ready(rdy[0]), .Busy(bsy[0]), .Err(er[0]));

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_STATES(0)) u_ws0 (
    .Clock(Clock), .clear(clear), .Read(rd[1]), .Write(wr[1]), .Addr(Addr), .Wdata(Wdata),
    .Mdatain(md[1]), .Ready(rdy[1]), .Busy(bsy[1]), .Err(er[1]));

  mem_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_STATES(3)) u_ws3 (
    .Clock(Clock), .clear(clear), .Read(rd[2]), .Write(wr[2]), .Addr(Addr), .Wdata(Wdata),
    .Mdatain(md[2]), .Ready(rdy[2]), .Busy(bsy[2]), .Err(er[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_md%0d", tag, i), md[i], 32'h0);
      check($sformatf("%s_rdy%0d", tag, i), {31'b0, rdy[i]}, 32'h0);
      check($sformatf("%s_bsy%0d", tag, i), {31'b0, bsy[i]}, 32'h0);
      check($sformatf("%s_err%0d", tag, i), {31'b0, er[i]}, 32'h0);
    end
  endtask

  // One complete transaction: hold the request 'hold' cycles past Ready, then release.
  task automatic txn(input int idx, input bit r, input bit w, input logic [8:0] a,
                     input logic [31:0] d, input int hold_in);
    bit err;
    int hold;
    int ws;
    hold = (hold_in < 1) ? 1 : hold_in;
    ws   = ws_of[idx];
    @(negedge Clock);
    rd[idx] = r; wr[idx] = w; Addr = a; Wdata = d;
    err = (r && w) || (int'(a) >= depth_of[idx]);
    if (!err && w) begin
      mem_m[idx][a] = d;
      kn[idx][a]    = 1'b1;
    end
    if (r && !w) mdm[idx] = err ? 32'h0 : mem_m[idx][a];
    @(posedge Clock);
    for (int k = 0; k <= ws + hold; k++) begin
      @(negedge Clock);
      if (k == 0) begin
        Addr  = 9'($urandom);
        Wdata = $urandom;
      end
      check($sformatf("busy_i%0d_k%0d", idx, k), {31'b0, bsy[idx]}, 32'h1);
      check($sformatf("ready_i%0d_k%0d", idx, k), {31'b0, rdy[idx]}, (k == ws) ? 32'h1 : 32'h0);
      if (k == ws) begin
        check($sformatf("err_i%0d_a%h", idx, a), {31'b0, er[idx]}, {31'b0, err});
        check($sformatf("mdata_i%0d_a%h", idx, a), md[idx], mdm[idx]);
      end
    end
    rd[idx] = 1'b0; wr[idx] = 1'b0;
    @(negedge Clock);
    check($sformatf("idle_busy_i%0d", idx), {31'b0, bsy[idx]}, 32'h0);
    check($sformatf("idle_ready_i%0d", idx), {31'b0, rdy[idx]}, 32'h0);
    check($sformatf("hold_mdata_i%0d", idx), md[idx], mdm[idx]);
  endtask

  initial begin
    logic [8:0]  ra;
    logic [31:0] rdat;
    int          op;

    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; mdm[i] = 32'h0;
      for (int j = 0; j < 512; j++) kn[i][j] = 1'b0;
    end
    Addr = '0; Wdata = '0;
    clear = 1'b0;
    #1;
    check_idle_outputs("reset");
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    clear = 1'b1;

    // Write then read, one wait state; read data persists.
    txn(0, 0, 1, 9'h010, 32'hFFFFFFF4, 1);
    txn(0, 1, 0, 9'h010, 32'h0, 1);
    repeat (10) @(negedge Clock);
    check("mdata_persist", md[0], 32'hFFFFFFF4);

    // Held read produces one Ready only.
    txn(0, 0, 1, 9'd5, 32'h12345678, 1);
    txn(0, 1, 0, 9'd5, 32'h0, 8);

    // Zero wait states.
    txn(1, 0, 1, 9'd5, 32'h00000005, 1);
    txn(1, 1, 0, 9'd5, 32'h0, 1);

    // Read+Write together leaves data and memory alone.
    txn(0, 0, 1, 9'd3, 32'hC0FFEE03, 1);
    txn(0, 1, 1, 9'd3, 32'hDEADBEEF, 1);
    txn(0, 1, 0, 9'd3, 32'h0, 1);
    txn(0, 1, 1, 9'd3, 32'h0BADF00D, 2);

    // Out-of-range read forces zero.
    txn(0, 1, 0, 9'h100, 32'h0, 1);

    // Inputs scrambled during the three wait cycles are ignored.
    txn(2, 0, 1, 9'h020, 32'h5A5A0F0F, 2);
    txn(2, 1, 0, 9'h020, 32'h0, 1);

    // Reset mid-write aborts it.
    txn(2, 0, 1, 9'd7, 32'h13579BDF, 1);
    @(negedge Clock);
    wr[2] = 1'b1; Addr = 9'd7; Wdata = 32'hAAAA5555;
    @(posedge Clock);
    @(negedge Clock);
    check("pre_reset_busy", {31'b0, bsy[2]}, 32'h1);
    clear = 1'b0;
    for (int i = 0; i < 3; i++) mdm[i] = 32'h0;
    #1;
    check_idle_outputs("midreset");
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock);
      check("reset_hold_ready", {31'b0, rdy[2]}, 32'h0);
    end
    wr[2] = 1'b0;
    clear = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clock);
      check("post_reset_ready", {31'b0, rdy[2]}, 32'h0);
      check("post_reset_busy", {31'b0, bsy[2]}, 32'h0);
    end
    txn(2, 1, 0, 9'd7, 32'h0, 1);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 15; n++) begin
        ra   = 9'($urandom % 16);
        if (i == 0 && ($urandom % 4) == 0) ra = 9'(256 + ($urandom % 256));
        rdat = $urandom;
        op   = int'($urandom % 8);
        if (op == 0) begin
          txn(i, 1, 1, ra, rdat, 1 + int'($urandom % 3));
        end else if (op <= 3 && (kn[i][ra] || int'(ra) >= depth_of[i])) begin
          txn(i, 1, 0, ra, rdat, 1 + int'($urandom % 3));
        end else begin
          txn(i, 0, 1, ra, rdat, 1 + int'($urandom % 3));
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
